mat_mul_ctrl: RTL and testbench
===============================

MAT_MUL_CTRL -- requirements
Module: mat_mul_ctrl

Interface
REQ-001 Parameter SYS_ARR_SIZE, default 8: maximum M, K and N dimension of the systolic array.
REQ-002 Parameter DIM_W, default 4: width of the cfg_m, cfg_k and cfg_n outputs; it SHALL hold SYS_ARR_SIZE.
REQ-003 Parameter PHASE_TIMEOUT, default 1024: watchdog limit, in cycles, for each of the LOAD, COMPUTE and DRAIN phases.
REQ-004 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 addr_sp_bram  out  32  SP_BRAM byte address.
REQ-007 enable_sp_bram  out  1  SP_BRAM port enable.
REQ-008 data_out_sp_bram  in  32  SP_BRAM read data, valid one cycle after its address is driven.
REQ-009 w_enable_sp_bram  out  4  SP_BRAM byte write enables.
REQ-010 data_in_sp_bram  out  32  SP_BRAM write data.
REQ-011 cfg_mode  out  1  dataflow select: 0 = weight-stationary (WS), 1 = output-stationary (OS).
REQ-012 cfg_m, cfg_k, cfg_n  out  DIM_W each  latched matrix dimensions.
REQ-013 load_start, compute_start, drain_start  out  1 each  one-cycle phase start pulses to the datapath.
REQ-014 load_done, compute_done, drain_done  in  1 each  phase-complete indications from the datapath, sampled only in the matching state.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, CHECK, LOAD, COMPUTE, DRAIN, STAT_WR and CLR_WR.
REQ-017 In IDLE: addr_sp_bram=0, enable_sp_bram=1, w_enable_sp_bram=0; on a rising edge where data_out_sp_bram==1 the FSM SHALL enter FETCH; any other value SHALL be ignored.
REQ-018 FETCH SHALL drive addr_sp_bram 4, 8, 12, 16 on four consecutive cycles with enable=1, then hold enable=1 with addr=16 for one extra capture cycle.
REQ-019 The word read at each address SHALL be captured on the edge one cycle after that address was driven: address 4 into mode, 8 into M, 12 into K, 16 into N.
REQ-020 CHECK SHALL last one cycle; it SHALL pass when mode is 0 or 1 and each of M, K and N is in the range 1..SYS_ARR_SIZE, using the full 32-bit compare.
REQ-021 On a CHECK pass: latch cfg_* from the captured words, pulse load_start, and enter LOAD; on a fail: set status=2 and enter STAT_WR.
REQ-022 LOAD SHALL wait for load_done, then pulse compute_start and enter COMPUTE.
REQ-023 COMPUTE SHALL wait for compute_done, then pulse drain_start and enter DRAIN.
REQ-024 DRAIN SHALL wait for drain_done, then set status=1 and enter STAT_WR.
REQ-025 Each start pulse SHALL be exactly one cycle long, asserted in the first cycle of the new state.
REQ-026 The phase counter SHALL clear on entry to LOAD, COMPUTE and DRAIN and SHALL saturate.
REQ-027 If a phase reaches PHASE_TIMEOUT cycles without its done signal: set status=3, enter STAT_WR, and issue no further start pulses.
REQ-028 A done input asserted outside its matching state SHALL be ignored; a done input asserted in the same cycle as its start pulse SHALL be accepted.
REQ-029 STAT_WR SHALL be one cycle: addr=100, enable=1, w_enable=4'b1111, data_in=status; next state CLR_WR.
REQ-030 CLR_WR SHALL be one cycle: addr=0, enable=1, w_enable=4'b1111, data_in=0, which clears the start word; next state IDLE.
REQ-031 cfg_* SHALL hold their values from CHECK until the next CHECK pass.
REQ-032 data_in_sp_bram SHALL be 0 whenever w_enable_sp_bram is 0.
REQ-033 A start word still reading 1 on the first IDLE cycle after CLR_WR (read latency) SHALL NOT retrigger the FSM; IDLE SHALL require one cycle of residence before sampling the start word.

Reset
REQ-034 While reset is 0: state=IDLE, addr_sp_bram=0, enable_sp_bram=1, w_enable_sp_bram=0, data_in_sp_bram=0.
REQ-035 While reset is 0: cfg_mode=0, cfg_m=cfg_k=cfg_n=0, all start pulses=0, busy=0, status=0, phase counter=0.
REQ-036 Reset asserted in any state SHALL abort the job without any SP_BRAM write.
REQ-037 The FSM SHALL be in IDLE on the first edge after reset releases.

Verification
REQ-038 Nominal WS job: start=1, mode=0, M=3, K=5, N=2; done inputs asserted 4 cycles after each start pulse -> addr sequence 4, 8, 12, 16; cfg=0/3/5/2; start pulses in order; write 1 to addr 100, then write 0 to addr 0; back in IDLE.
REQ-039 Dimension sweep: all M, K, N in 1..8 for both modes -> every job completes with status 1 and correct cfg_* values.
REQ-040 Invalid config: K=0, then separately N=9, then separately mode=2 -> no start pulse; status 2 written to addr 100; then 0 written to addr 0.
REQ-041 Timeout: compute_done held at 0 -> status 3 written at addr 100 exactly PHASE_TIMEOUT cycles after entry to COMPUTE; no drain_start pulse.
REQ-042 Reset mid-DRAIN -> all outputs at their reset values immediately; no write to addr 100; a fresh start=1 then completes normally.
REQ-043 Spurious done: load_done pulsed while in IDLE and drain_done pulsed while in LOAD -> no state change; a later nominal job is unaffected.

Source files
------------

// File: rtl/mat_mul_ctrl.sv
// rtl/mat_mul_ctrl.sv - SP_BRAM-driven job sequencer for the systolic matrix-multiply datapath
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   addr_sp_bram      SP_BRAM byte address
//   enable_sp_bram    SP_BRAM port enable
//   data_out_sp_bram  SP_BRAM read data (one-cycle read latency)
//   w_enable_sp_bram  SP_BRAM byte write enables
//   data_in_sp_bram   SP_BRAM write data
//   cfg_mode          dataflow select, 0 = weight-stationary, 1 = output-stationary
//   cfg_m/k/n         latched matrix dimensions
//   load_start, compute_start, drain_start  one-cycle phase start pulses
//   load_done, compute_done, drain_done     phase-complete inputs
//   busy              high whenever the sequencer is not idle
//
// SP_BRAM word map: 0 start word, 4 mode, 8 M, 12 K, 16 N, 100 status.
// Status codes: 1 done, 2 bad configuration, 3 phase timeout.

module mat_mul_ctrl #(
  parameter int SYS_ARR_SIZE  = 8,
  parameter int DIM_W         = 4,
  parameter int PHASE_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      addr_sp_bram,
  output logic             enable_sp_bram,
  input  logic [31:0]      data_out_sp_bram,
  output logic [3:0]       w_enable_sp_bram,
  output logic [31:0]      data_in_sp_bram,
  output logic             cfg_mode,
  output logic [DIM_W-1:0] cfg_m,
  output logic [DIM_W-1:0] cfg_k,
  output logic [DIM_W-1:0] cfg_n,
  output logic             load_start,
  output logic             compute_start,
  output logic             drain_start,
  input  logic             load_done,
  input  logic             compute_done,
  input  logic             drain_done,
  output logic             busy
);

  localparam int                PCNT_W    = $clog2(PHASE_TIMEOUT + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PHASE_TIMEOUT - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX  = '1;

  localparam logic [31:0] ADDR_START  = 32'd0;
  localparam logic [31:0] ADDR_N      = 32'd16;
  localparam logic [31:0] ADDR_STATUS = 32'd100;
  localparam logic [31:0] DIM_MAX     = 32'(SYS_ARR_SIZE);
  localparam logic [2:0]  FETCH_LAST  = 3'd4;

  localparam logic [1:0] ST_DONE    = 2'd1;
  localparam logic [1:0] ST_CFG_ERR = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_STAT_WR,
    S_CLR_WR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        fetch_cnt;
  logic              idle_armed;
  logic [31:0]       mode_word;
  logic [31:0]       m_word;
  logic [31:0]       k_word;
  logic [31:0]       n_word;
  logic [1:0]        status;
  logic [PCNT_W-1:0] phase_cnt;

  logic              cfg_ok;
  logic              in_phase;
  logic              phase_done;
  logic              timeout_hit;

  // Full 32-bit range checks so a large word with small low bits is rejected.
  assign cfg_ok = (mode_word <= 32'd1) &&
                  (m_word >= 32'd1) && (m_word <= DIM_MAX) &&
                  (k_word >= 32'd1) && (k_word <= DIM_MAX) &&
                  (n_word >= 32'd1) && (n_word <= DIM_MAX);

  assign in_phase = (state == S_LOAD) || (state == S_COMPUTE) || (state == S_DRAIN);

  // Each done input only counts while the sequencer sits in its own phase.
  assign phase_done = ((state == S_LOAD)    && load_done)    ||
                      ((state == S_COMPUTE) && compute_done) ||
                      ((state == S_DRAIN)   && drain_done);

  // The last allowed phase cycle has phase_cnt == PHASE_TIMEOUT-1; done wins a tie.
  assign timeout_hit = in_phase && !phase_done && (phase_cnt >= PCNT_LAST);

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt        = state;
    addr_sp_bram     = 32'd0;
    enable_sp_bram   = 1'b0;
    w_enable_sp_bram = 4'b0000;
    data_in_sp_bram  = 32'd0;
    case (state)
      S_IDLE: begin
        addr_sp_bram   = ADDR_START;
        enable_sp_bram = 1'b1;
        // idle_armed masks the stale start word read back during CLR_WR.
        if (idle_armed && (data_out_sp_bram == 32'd1)) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        enable_sp_bram = 1'b1;
        // Addresses 4..16 on counts 0..3; count 4 re-drives 16 while N is captured.
        if (fetch_cnt == FETCH_LAST) begin
          addr_sp_bram = ADDR_N;
          state_nxt    = S_CHECK;
        end else begin
          addr_sp_bram = {27'd0, fetch_cnt + 3'd1, 2'b00};
        end
      end
      S_CHECK: begin
        state_nxt = cfg_ok ? S_LOAD : S_STAT_WR;
      end
      S_LOAD: begin
        if (load_done) begin
          state_nxt = S_COMPUTE;
        end else if (timeout_hit) begin
          state_nxt = S_STAT_WR;
        end
      end
      S_COMPUTE: begin
        if (compute_done) begin
          state_nxt = S_DRAIN;
        end else if (timeout_hit) begin
          state_nxt = S_STAT_WR;
        end
      end
      S_DRAIN: begin
        if (drain_done || timeout_hit) begin
          state_nxt = S_STAT_WR;
        end
      end
      S_STAT_WR: begin
        addr_sp_bram     = ADDR_STATUS;
        enable_sp_bram   = 1'b1;
        w_enable_sp_bram = 4'b1111;
        data_in_sp_bram  = {30'd0, status};
        state_nxt        = S_CLR_WR;
      end
      S_CLR_WR: begin
        addr_sp_bram     = ADDR_START;
        enable_sp_bram   = 1'b1;
        w_enable_sp_bram = 4'b1111;
        data_in_sp_bram  = 32'd0;
        state_nxt        = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      fetch_cnt     <= 3'd0;
      idle_armed    <= 1'b0;
      mode_word     <= 32'd0;
      m_word        <= 32'd0;
      k_word        <= 32'd0;
      n_word        <= 32'd0;
      status        <= 2'd0;
      phase_cnt     <= '0;
      cfg_mode      <= 1'b0;
      cfg_m         <= '0;
      cfg_k         <= '0;
      cfg_n         <= '0;
      load_start    <= 1'b0;
      compute_start <= 1'b0;
      drain_start   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle_armed <= (state == S_IDLE);

      if (state == S_FETCH) begin
        fetch_cnt <= fetch_cnt + 3'd1;
      end else begin
        fetch_cnt <= 3'd0;
      end

      // Read data lags the address by one cycle, so count k captures address 4*k.
      if (state == S_FETCH) begin
        case (fetch_cnt)
          3'd1:    mode_word <= data_out_sp_bram;
          3'd2:    m_word    <= data_out_sp_bram;
          3'd3:    k_word    <= data_out_sp_bram;
          3'd4:    n_word    <= data_out_sp_bram;
          default: ;
        endcase
      end

      // Any state change clears the counter, which covers every phase entry.
      if (state_nxt != state) begin
        phase_cnt <= '0;
      end else if (in_phase && (phase_cnt != PCNT_MAX)) begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      if ((state == S_CHECK) && cfg_ok) begin
        cfg_mode <= mode_word[0];
        cfg_m    <= m_word[DIM_W-1:0];
        cfg_k    <= k_word[DIM_W-1:0];
        cfg_n    <= n_word[DIM_W-1:0];
      end

      if ((state == S_CHECK) && !cfg_ok) begin
        status <= ST_CFG_ERR;
      end else if ((state == S_DRAIN) && drain_done) begin
        status <= ST_DONE;
      end else if (timeout_hit) begin
        status <= ST_TIMEOUT;
      end

      // Registered so each pulse lands in the first cycle of the state it starts.
      load_start    <= (state == S_CHECK) && cfg_ok;
      compute_start <= (state == S_LOAD) && load_done;
      drain_start   <= (state == S_COMPUTE) && compute_done;
    end
  end

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// tb/tb_mat_mul_ctrl.sv - directed-vector bench for mat_mul_ctrl
module tb_mat_mul_ctrl;

  localparam int PT = 1024;

  logic        clk;
  logic        reset;
  logic [31:0] addr_sp_bram;
  logic        enable_sp_bram;
  logic [31:0] data_out_sp_bram = 32'd0;
  logic [3:0]  w_enable_sp_bram;
  logic [31:0] data_in_sp_bram;
  logic        cfg_mode;
  logic [3:0]  cfg_m;
  logic [3:0]  cfg_k;
  logic [3:0]  cfg_n;
  logic        load_start;
  logic        compute_start;
  logic        drain_start;
  logic        load_done;
  logic        compute_done;
  logic        drain_done;
  logic        busy;

  mat_mul_ctrl #(
    .SYS_ARR_SIZE (8),
    .DIM_W        (4),
    .PHASE_TIMEOUT(PT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .addr_sp_bram    (addr_sp_bram),
    .enable_sp_bram  (enable_sp_bram),
    .data_out_sp_bram(data_out_sp_bram),
    .w_enable_sp_bram(w_enable_sp_bram),
    .data_in_sp_bram (data_in_sp_bram),
    .cfg_mode        (cfg_mode),
    .cfg_m           (cfg_m),
    .cfg_k           (cfg_k),
    .cfg_n           (cfg_n),
    .load_start      (load_start),
    .compute_start   (compute_start),
    .drain_start     (drain_start),
    .load_done       (load_done),
    .compute_done    (compute_done),
    .drain_done      (drain_done),
    .busy            (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [0:31] = '{default: 32'd0};
  logic [31:0] host_w [0:4];
  int          host_req = 0;
  int          host_ack = 0;

  logic [31:0] wr_a [$];
  logic [31:0] wr_d [$];
  int          wr_c [$];
  logic [31:0] rd_a [$];
  int          st_q [$];
  int          cyc = 0;
  int          cs_cyc = 0;

  always @(posedge clk) begin
    if (enable_sp_bram) begin
      data_out_sp_bram <= mem[addr_sp_bram[6:2]];
      for (int b = 0; b < 4; b++) begin
        if (w_enable_sp_bram[b]) mem[addr_sp_bram[6:2]][8*b +: 8] = data_in_sp_bram[8*b +: 8];
      end
    end
    if (host_req != host_ack) begin
      for (int i = 0; i < 5; i++) mem[i] = host_w[i];
      host_ack = host_req;
    end
    if (reset) begin
      if (w_enable_sp_bram != 4'd0) begin
        wr_a.push_back(addr_sp_bram);
        wr_d.push_back(data_in_sp_bram);
        wr_c.push_back(cyc);
      end
      if (busy && enable_sp_bram && (w_enable_sp_bram == 4'd0)) rd_a.push_back(addr_sp_bram);
      if (load_start) st_q.push_back(1);
      if (compute_start) begin
        st_q.push_back(2);
        cs_cyc = cyc;
      end
      if (drain_start) st_q.push_back(3);
    end
    cyc = cyc + 1;
  end

  logic man_ld, man_cd, man_dd;
  logic auto_ld, auto_cd, auto_dd;
  logic en_ld, en_cd, en_dd;
  int   done_delay;
  int   ld_cnt, cd_cnt, dd_cnt;

  assign load_done    = auto_ld | man_ld;
  assign compute_done = auto_cd | man_cd;
  assign drain_done   = auto_dd | man_dd;

  initial begin
    auto_ld = 1'b0; auto_cd = 1'b0; auto_dd = 1'b0;
    ld_cnt = 0; cd_cnt = 0; dd_cnt = 0;
    forever begin
      @(negedge clk);
      auto_ld = 1'b0; auto_cd = 1'b0; auto_dd = 1'b0;
      if (ld_cnt > 0) begin ld_cnt--; if (ld_cnt == 0) auto_ld = 1'b1; end
      if (cd_cnt > 0) begin cd_cnt--; if (cd_cnt == 0) auto_cd = 1'b1; end
      if (dd_cnt > 0) begin dd_cnt--; if (dd_cnt == 0) auto_dd = 1'b1; end
      if (load_start && en_ld) begin
        if (done_delay == 0) auto_ld = 1'b1; else ld_cnt = done_delay;
      end
      if (compute_start && en_cd) begin
        if (done_delay == 0) auto_cd = 1'b1; else cd_cnt = done_delay;
      end
      if (drain_start && en_dd) begin
        if (done_delay == 0) auto_dd = 1'b1; else dd_cnt = done_delay;
      end
    end
  end

  int wr_base, rd_base, st_base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int seq_since(input int base);
    int s = 0;
    for (int i = base; i < st_q.size(); i++) s = s * 4 + st_q[i];
    return s;
  endfunction

  task automatic start_job(input int md, input int m, input int k, input int n);
    host_w[0] = 32'd1;
    host_w[1] = 32'(md);
    host_w[2] = 32'(m);
    host_w[3] = 32'(k);
    host_w[4] = 32'(n);
    wr_base = wr_a.size();
    rd_base = rd_a.size();
    st_base = st_q.size();
    host_req++;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int c = 0;
    while ((seq_since(st_base) != target) && (c < budget)) begin
      @(negedge clk);
      c++;
    end
    chk("start wait", 32'(seq_since(st_base)), 32'(target));
  endtask

  task automatic finish_job(input string tag, input int exp_status, input int exp_seq,
                            input int e_mode, input int e_m, input int e_k, input int e_n);
    int c = 0;
    while ((wr_a.size() < wr_base + 2) && (c < 3000)) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " writes seen"}, 32'(wr_a.size() >= wr_base + 2), 32'd1);
    if (wr_a.size() >= wr_base + 2) begin
      chk({tag, " status addr"}, wr_a[wr_base], 32'd100);
      chk({tag, " status data"}, wr_d[wr_base], 32'(exp_status));
      chk({tag, " clear addr"}, wr_a[wr_base+1], 32'd0);
      chk({tag, " clear data"}, wr_d[wr_base+1], 32'd0);
    end
    chk({tag, " start seq"}, 32'(seq_since(st_base)), 32'(exp_seq));
    chk({tag, " cfg_mode"}, 32'(cfg_mode), 32'(e_mode));
    chk({tag, " cfg_m"}, 32'(cfg_m), 32'(e_m));
    chk({tag, " cfg_k"}, 32'(cfg_k), 32'(e_k));
    chk({tag, " cfg_n"}, 32'(cfg_n), 32'(e_n));
    repeat (2) @(negedge clk);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " start word"}, mem[0], 32'd0);
    chk({tag, " write count"}, 32'(wr_a.size() - wr_base), 32'd2);
  endtask

  logic [31:0] exp_rd [0:4];

  initial begin
    reset = 1'b1;
    man_ld = 1'b0; man_cd = 1'b0; man_dd = 1'b0;
    en_ld = 1'b1; en_cd = 1'b1; en_dd = 1'b1;
    done_delay = 4;
    wr_base = 0; rd_base = 0; st_base = 0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst addr", addr_sp_bram, 32'd0);
    chk("rst en", 32'(enable_sp_bram), 32'd1);
    chk("rst wen", 32'(w_enable_sp_bram), 32'd0);
    chk("rst din", data_in_sp_bram, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cfg", {cfg_mode, cfg_m, cfg_k, cfg_n}, 32'd0);
    chk("rst starts", {load_start, compute_start, drain_start}, 32'd0);
    reset = 1'b1;

    repeat (2) @(negedge clk);
    man_ld = 1'b1;
    @(negedge clk);
    man_ld = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle spurious busy", 32'(busy), 32'd0);
    chk("idle spurious starts", 32'(st_q.size()), 32'd0);

    start_job(0, 3, 5, 2);
    finish_job("nominal", 1, 27, 0, 3, 5, 2);
    exp_rd = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd16};
    chk("nominal read count", 32'(rd_a.size() - rd_base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (rd_a.size() > rd_base + i) chk("nominal read addr", rd_a[rd_base+i], exp_rd[i]);
    end

    start_job(0, 3, 0, 2);
    finish_job("bad k", 2, 0, 0, 3, 5, 2);
    start_job(0, 3, 5, 9);
    finish_job("bad n", 2, 0, 0, 3, 5, 2);
    start_job(2, 3, 5, 2);
    finish_job("bad mode", 2, 0, 0, 3, 5, 2);

    en_cd = 1'b0;
    start_job(1, 8, 8, 8);
    finish_job("timeout", 3, 6, 1, 8, 8, 8);
    if (wr_c.size() > wr_base) chk("timeout cycles", 32'(wr_c[wr_base] - cs_cyc), 32'(PT));
    en_cd = 1'b1;

    en_dd = 1'b0;
    start_job(0, 4, 4, 4);
    wait_starts(27, 200);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid rst addr", addr_sp_bram, 32'd0);
    chk("mid rst en", 32'(enable_sp_bram), 32'd1);
    chk("mid rst wen", 32'(w_enable_sp_bram), 32'd0);
    chk("mid rst din", data_in_sp_bram, 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst cfg", {cfg_mode, cfg_m, cfg_k, cfg_n}, 32'd0);
    chk("mid rst starts", {load_start, compute_start, drain_start}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid rst no write", 32'(wr_a.size() - wr_base), 32'd0);
    en_dd = 1'b1;
    reset = 1'b1;
    start_job(0, 4, 4, 4);
    finish_job("post reset", 1, 27, 0, 4, 4, 4);

    done_delay = 6;
    start_job(1, 2, 3, 4);
    wait_starts(1, 100);
    man_dd = 1'b1;
    @(negedge clk);
    man_dd = 1'b0;
    chk("load spurious busy", 32'(busy), 32'd1);
    chk("load spurious seq", 32'(seq_since(st_base)), 32'd1);
    chk("load spurious writes", 32'(wr_a.size() - wr_base), 32'd0);
    finish_job("spurious load", 1, 27, 1, 2, 3, 4);
    done_delay = 4;
    start_job(0, 5, 6, 7);
    finish_job("after spurious", 1, 27, 0, 5, 6, 7);

    done_delay = 0;
    for (int md = 0; md < 2; md++) begin
      for (int m = 1; m <= 8; m++) begin
        for (int k = 1; k <= 8; k++) begin
          for (int n = 1; n <= 8; n++) begin
            start_job(md, m, k, n);
            finish_job("sweep", 1, 27, md, m, k, n);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
